iir_biquad_tdm: RTL
===================

# iir_biquad_tdm

Time-multiplexed, parametrised second-order (biquad) IIR filter serving NCH independent channels with one shared multiplier datapath. Each channel has its own coefficient bank and its own direct-form-I state. Samples arrive tagged with a channel index through a valid/ready handshake, and results leave tagged with the same index. It is the multichannel, runtime-programmable generalisation of the fixed single-channel 2nd-order filter, placed between the sample source (data_gen) and the sample sink (data_save).

## Interface
- W, 12, sample and coefficient width; samples are signed integers, coefficients are signed Q1.(W-1)
- NCH, 4, number of channels (2..16)
- CHW, 2, channel index width; must satisfy 2^CHW >= NCH
- CLK  in  1  clock; all registers on the rising edge
- RST  in  1  asynchronous, active-high reset
- DIN  in  W  input sample
- VIN  in  1  input valid
- CH_IN  in  CHW  channel of DIN
- RDY  out  1  ready; a sample is accepted at a rising edge where VIN=1 and RDY=1
- DOUT  out  W  filtered sample
- VOUT  out  1  DOUT/CH_OUT/OVF valid; one-cycle pulse per result
- CH_OUT  out  CHW  channel of DOUT
- OVF  out  1  result was saturated (qualified by VOUT)
- COEF_WE  in  1  coefficient write strobe
- COEF_CH  in  CHW  channel being written
- COEF_SEL  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; values 5..7 ignored
- COEF_DATA  in  W  coefficient value
- FLUSH  in  1  synchronous clear of the state of all channels

## Operation
- Filter equation per channel: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
- Per-channel state is x1, x2, y1, y2, each W bits. Per-channel coefficients are b0, b1, b2, a1, a2.
- Arithmetic:
  - Each product is a 2W-bit signed value.
  - The five products are summed exactly in a (2W+3)-bit accumulator.
  - y = acc >>> (W-1), which is arithmetic shift, i.e. floor.
  - If y > 2^(W-1)−1, clamp to 2^(W-1)−1 and set OVF=1. If y < −2^(W-1), clamp to −2^(W-1) and set OVF=1.
- Pipeline stage S1 (register at the accept edge) captures:
  - DIN and CH_IN;
  - the channel's x1, x2, y1, y2;
  - the channel's five coefficients;
  - s1_valid.
- Pipeline stage S2: combinational multiply-accumulate from S1. At the next edge it:
  - registers DOUT, CH_OUT, OVF and VOUT=1;
  - writes back x2←x1, x1←x, y2←y1, y1←y_saturated for that channel.
- Hazard: RDY = !RST && !FLUSH && !(s1_valid && CH_IN == s1_ch). Two samples for the same channel are therefore at least 2 cycles apart. Samples for different channels may be accepted every cycle.
- CH_IN >= NCH: the sample is accepted (RDY follows the rule above), then dropped. No VOUT, no state change.
- Coefficient write: takes effect at the edge where COEF_WE=1; invalid channel or select is ignored. A sample accepted at the same edge captures the old value. A sample already in S1 keeps its captured value.
- FLUSH=1 at an edge:
  - zeroes x1, x2, y1, y2 of every channel;
  - has priority over a write-back at the same edge;
  - lets the sample in flight still produce its output;
  - leaves coefficients unchanged.

## Timing
- Reset values:
  - DOUT=0, VOUT=0, CH_OUT=0, OVF=0;
  - all state and all coefficients 0;
  - s1_valid=0;
  - RDY=0 while RST=1.
- Latency: a sample accepted at edge t appears with VOUT=1 in the cycle after edge t+1. That is 2 edges; throughput is 1 sample per cycle across channels.
- VOUT is high for exactly one cycle per accepted valid-channel sample. Results keep acceptance order.
- RST asserted mid-operation: the in-flight sample is discarded and no VOUT is produced. Operation restarts from the reset values above.
- A back-to-back same-channel request produces RDY=0 for one cycle, then acceptance.

## Test plan
- Impulse, ch0: b0=1024 (0.5), others 0; accept DIN=1000 → DOUT=500, CH_OUT=0, OVF=0, two edges after acceptance.
- Recursion, ch1: b0=1024, a1=0xC00 (−0.5); impulse 1000 followed by zeros, spaced ≥2 cycles → DOUT sequence 500, 250, 125, 62, 31.
- Saturation, ch2: b0=b1=2047; DIN=2047, then 2047 → DOUT=2045 with OVF=0, then 2047 with OVF=1. With the input negated (−2048 twice, same coefficients) → second DOUT=−2048 with OVF=1.
- Hazard and interleave:
  - VIN held high on ch0 for 6 cycles → RDY toggles 1/0 and VOUT pulses every other cycle.
  - Alternating ch0/ch1 → RDY stays 1 and VOUT is high every cycle.
  - Per-channel outputs match separate single-channel runs.
- Coefficient and FLUSH:
  - Writing b0 at the same edge as acceptance → that sample uses the old b0, and the next sample uses the new one.
  - FLUSH mid-stream in the recursion case → the next result equals 0.5·x only (1000 → 500).
- Reset mid-operation: assert RST with a sample in S1 → no VOUT; all outputs 0; after release, DIN=1000 with unprogrammed coefficients gives DOUT=0.

Source files
------------

// File: rtl/iir_biquad_tdm_if.sv
// Sample, result and coefficient-programming bus of the time-multiplexed biquad.
interface iir_biquad_tdm_if #(
    parameter int W   = 12,
    parameter int CHW = 2
);
    logic [W-1:0]   DIN;
    logic           VIN;
    logic [CHW-1:0] CH_IN;
    logic           RDY;
    logic [W-1:0]   DOUT;
    logic           VOUT;
    logic [CHW-1:0] CH_OUT;
    logic           OVF;
    logic           COEF_WE;
    logic [CHW-1:0] COEF_CH;
    logic [2:0]     COEF_SEL;
    logic [W-1:0]   COEF_DATA;
    logic           FLUSH;

    modport master (output DIN, VIN, CH_IN, COEF_WE, COEF_CH, COEF_SEL, COEF_DATA, FLUSH,
                    input  RDY, DOUT, VOUT, CH_OUT, OVF);
    modport slave  (input  DIN, VIN, CH_IN, COEF_WE, COEF_CH, COEF_SEL, COEF_DATA, FLUSH,
                    output RDY, DOUT, VOUT, CH_OUT, OVF);
endinterface

// File: rtl/iir_biquad_tdm.sv
// NCH-channel direct-form-I biquad sharing one multiply-accumulate datapath.
// Per-channel coefficient bank and x/y history live in iir_biquad_tdm_chan.
module iir_biquad_tdm_chan #(
    parameter int W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           coef_we,
    input  logic [2:0]     coef_sel,
    input  logic [W-1:0]   coef_data,
    input  logic           wb_en,
    input  logic [W-1:0]   wb_x,
    input  logic [W-1:0]   wb_y,
    input  logic           flush,
    output logic [5*W-1:0] coef,   // {b0, b1, b2, a1, a2}
    output logic [4*W-1:0] state   // {x1, x2, y1, y2}
);
    logic [4:0][W-1:0] c_q;
    logic [3:0][W-1:0] s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
        end else if (coef_we) begin
            case (coef_sel)
                3'd0:    c_q[4] <= coef_data;
                3'd1:    c_q[3] <= coef_data;
                3'd2:    c_q[2] <= coef_data;
                3'd3:    c_q[1] <= coef_data;
                3'd4:    c_q[0] <= coef_data;
                default: ;
            endcase
        end
    end

    // flush wins over the write-back of the sample leaving S1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        s_q <= '0;
        else if (flush) s_q <= '0;
        else if (wb_en) s_q <= {wb_x, s_q[3], wb_y, s_q[1]};
    end

    assign coef  = c_q;
    assign state = s_q;
endmodule

module iir_biquad_tdm #(
    parameter int W   = 12,
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input logic             CLK,
    input logic             RST,
    iir_biquad_tdm_if.slave bus
);
    localparam int PW     = 2 * W;
    localparam int AW     = 2 * W + 3;
    localparam int STAGES = 1;
    localparam logic signed [AW-1:0] YMAX = (AW'(1) <<< (W - 1)) - AW'(1);
    localparam logic signed [AW-1:0] YMIN = ~YMAX;

    typedef struct packed { logic signed [W-1:0] b0, b1, b2, a1, a2; } coef_t;
    typedef struct packed { logic signed [W-1:0] x1, x2, y1, y2; } state_t;
    typedef struct packed {
        logic [CHW-1:0]      ch;
        logic signed [W-1:0] x;
        coef_t               c;
        state_t              s;
    } s1_t;

    logic [NCH-1:0][5*W-1:0] coef_v;
    logic [NCH-1:0][4*W-1:0] state_v;
    logic [NCH-1:0]          ch_hit;
    logic [STAGES:0]         vld_pipe;   // [0] = S1 valid, [1] = VOUT
    s1_t                     s1, s1_d;
    logic                    accept;
    logic signed [PW-1:0]    p0, p1, p2, p3, p4;
    logic signed [AW-1:0]    acc, yw;
    logic [W-1:0]            y_sat;
    logic                    ovf_d;
    logic [W-1:0]            dout_q;
    logic [CHW-1:0]          ch_out_q;
    logic                    ovf_q;

    genvar c;
    for (c = 0; c < NCH; c++) begin : g_ch
        assign ch_hit[c] = (bus.CH_IN == CHW'(c));
        iir_biquad_tdm_chan #(.W(W)) u_chan (
            .clk       (CLK),
            .rst       (RST),
            .coef_we   (bus.COEF_WE && (bus.COEF_CH == CHW'(c))),
            .coef_sel  (bus.COEF_SEL),
            .coef_data (bus.COEF_DATA),
            .wb_en     (vld_pipe[0] && (s1.ch == CHW'(c))),
            .wb_x      (s1.x),
            .wb_y      (y_sat),
            .flush     (bus.FLUSH),
            .coef      (coef_v[c]),
            .state     (state_v[c])
        );
    end

    // Same-channel back-to-back is held off so S1 always reads written-back history
    assign bus.RDY = !RST && !bus.FLUSH && !(vld_pipe[0] && (bus.CH_IN == s1.ch));
    assign accept  = bus.VIN && bus.RDY;

    always_comb begin
        s1_d    = '0;
        s1_d.ch = bus.CH_IN;
        s1_d.x  = bus.DIN;
        for (int i = 0; i < NCH; i++) begin
            if (ch_hit[i]) begin
                s1_d.c = coef_v[i];
                s1_d.s = state_v[i];
            end
        end
    end

    // Out-of-range channels are accepted but never enter the valid pipe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:0], accept && (|ch_hit)};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         s1 <= '0;
        else if (accept) s1 <= s1_d;
    end

    always_comb begin
        p0    = PW'($signed(s1.c.b0)) * PW'($signed(s1.x));
        p1    = PW'($signed(s1.c.b1)) * PW'($signed(s1.s.x1));
        p2    = PW'($signed(s1.c.b2)) * PW'($signed(s1.s.x2));
        p3    = PW'($signed(s1.c.a1)) * PW'($signed(s1.s.y1));
        p4    = PW'($signed(s1.c.a2)) * PW'($signed(s1.s.y2));
        acc   = AW'(p0) + AW'(p1) + AW'(p2) - AW'(p3) - AW'(p4);
        yw    = acc >>> (W - 1);
        y_sat = yw[W-1:0];
        ovf_d = 1'b0;
        if (yw > YMAX) begin
            y_sat = YMAX[W-1:0];
            ovf_d = 1'b1;
        end else if (yw < YMIN) begin
            y_sat = YMIN[W-1:0];
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q   <= '0;
            ch_out_q <= '0;
            ovf_q    <= 1'b0;
        end else if (vld_pipe[0]) begin
            dout_q   <= y_sat;
            ch_out_q <= s1.ch;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.DOUT   = dout_q;
    assign bus.CH_OUT = ch_out_q;
    assign bus.OVF    = ovf_q;
    assign bus.VOUT   = vld_pipe[STAGES];
endmodule
